// File: rtl/clint_mhart.sv
// Multi-hart core-local interruptor: msip, mtimecmp and mtime registers with timer compare.
// Optional mtime prescaler enabled by defining CLINT_PRESCALE_EN (ticks once every DIV clocks).
module clint_mhart #(
  parameter int unsigned HARTS = 2,
  parameter int unsigned DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clint_re_i,
  input  logic [15:0]      clint_raddr_i,
  output logic [63:0]      clint_rdata_o,
  output logic             clint_rvalid_o,
  output logic             clint_rerr_o,
  input  logic             clint_we_i,
  input  logic [15:0]      clint_waddr_i,
  input  logic [63:0]      clint_wdata_i,
  input  logic [7:0]       clint_wstrb_i,
  output logic             clint_werr_o,
  output logic [HARTS-1:0] msip,
  output logic [HARTS-1:0] mtip
);

  localparam logic [15:0] MtimeAddr = 16'hBFF8;
  localparam logic [15:0] CmpBase   = 16'h4000;

  logic [63:0]             mtime_q, mtime_d;
  logic [HARTS-1:0][63:0]  cmp_q, cmp_d;
  logic [HARTS-1:0]        msip_q, msip_d;
  logic [HARTS-1:0]        mtip_q, mtip_d;
  logic [63:0]             rdata_q;
  logic                    rvalid_q, rerr_q, werr_q;

  logic                    tick;
  logic [63:0]             wmask;
  logic                    rd_mtime, wr_mtime;
  logic [HARTS-1:0]        rd_msip, rd_cmp, wr_msip, wr_cmp;
  logic [HARTS:0][63:0]    rd_acc;
  logic                    rd_hit, wr_hit;

  assign wmask = {{8{clint_wstrb_i[7]}}, {8{clint_wstrb_i[6]}}, {8{clint_wstrb_i[5]}},
                  {8{clint_wstrb_i[4]}}, {8{clint_wstrb_i[3]}}, {8{clint_wstrb_i[2]}},
                  {8{clint_wstrb_i[1]}}, {8{clint_wstrb_i[0]}}};

  assign rd_mtime  = (clint_raddr_i == MtimeAddr);
  assign wr_mtime  = clint_we_i && (clint_waddr_i == MtimeAddr);
  assign rd_acc[0] = rd_mtime ? mtime_q : 64'd0;

  for (genvar h = 0; h < HARTS; h++) begin : g_hart
    localparam logic [15:0] MsipAddr = 16'(4 * h);
    localparam logic [15:0] CmpAddr  = CmpBase + 16'(8 * h);

    assign rd_msip[h] = (clint_raddr_i == MsipAddr);
    assign rd_cmp[h]  = (clint_raddr_i == CmpAddr);
    assign wr_msip[h] = clint_we_i && (clint_waddr_i == MsipAddr);
    assign wr_cmp[h]  = clint_we_i && (clint_waddr_i == CmpAddr);

    // Decodes are mutually exclusive, so an OR-chain forms the read mux.
    assign rd_acc[h+1] = rd_acc[h]
                       | (rd_cmp[h]  ? cmp_q[h] : 64'd0)
                       | (rd_msip[h] ? {63'd0, msip_q[h]} : 64'd0);

    assign cmp_d[h]  = wr_cmp[h] ? ((cmp_q[h] & ~wmask) | (clint_wdata_i & wmask)) : cmp_q[h];
    assign msip_d[h] = (wr_msip[h] && clint_wstrb_i[0]) ? clint_wdata_i[0] : msip_q[h];
    assign mtip_d[h] = (mtime_q >= cmp_q[h]);
  end

  assign rd_hit = rd_mtime | (|rd_msip) | (|rd_cmp);
  assign wr_hit = wr_mtime | (|wr_msip) | (|wr_cmp);

`ifdef CLINT_PRESCALE_EN
  logic [7:0] presc_q, presc_d;

  always_comb begin
    tick    = (presc_q == 8'(DIV - 1));
    presc_d = tick ? 8'd0 : presc_q + 8'd1;
    if (wr_mtime) begin
      presc_d = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= 8'd0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  logic unused_div;
  assign unused_div = (DIV == 32'd0);
  assign tick       = 1'b1;
`endif

  // A software write to mtime wins over a coincident tick.
  always_comb begin
    mtime_d = mtime_q;
    if (wr_mtime) begin
      mtime_d = (mtime_q & ~wmask) | (clint_wdata_i & wmask);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime_q  <= 64'd0;
      cmp_q    <= '1;
      msip_q   <= '0;
      mtip_q   <= '0;
      rdata_q  <= 64'd0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      werr_q   <= 1'b0;
    end else begin
      mtime_q  <= mtime_d;
      cmp_q    <= cmp_d;
      msip_q   <= msip_d;
      mtip_q   <= mtip_d;
      rvalid_q <= clint_re_i;
      rerr_q   <= clint_re_i && !rd_hit;
      werr_q   <= clint_we_i && !wr_hit;
      if (clint_re_i) begin
        rdata_q <= rd_acc[HARTS];
      end
    end
  end

  assign clint_rdata_o  = rdata_q;
  assign clint_rvalid_o = rvalid_q;
  assign clint_rerr_o   = rerr_q;
  assign clint_werr_o   = werr_q;
  assign msip           = msip_q;
  assign mtip           = mtip_q;

endmodule
